pe_row_sched: RTL and testbench
===============================

Name: pe_row_sched

Overview:
- Sequencer for one PE row: 7 binary PEs, each 27-bit XNOR-popcount, psum chained PE to PE, WIDTH-bit psum.
- Per job: loads one weight tile per pass and streams num_pix activation windows into the row.
- Selects psum_in source: zero on the first pass, psum buffer on later passes.
- Tracks the fixed-latency psum pipeline so each row result is written back to the psum buffer at the right address; final-pass writes are flagged.

Parameters:
- ROW_LENGTH, 7, PEs in the row; also the psum pipeline latency in cycles (PE_LAT = ROW_LENGTH).
- PIX_W, 10, width of pixel count and psum buffer address.
- PASS_W, 4, width of pass count and weight tile index.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- start_in  in  1  job start pulse; accepted only in IDLE.
- num_pix_in  in  PIX_W  windows per pass; latched at start.
- num_pass_in  in  PASS_W  weight tiles (passes) per job; latched at start.
- busy_out  out  1  high in any state except IDLE.
- done_out  out  1  one-cycle job-complete pulse.
- wgt_load_out  out  1  one-cycle pulse: weight buffer drives tile wgt_tile_out into the row's weight registers.
- wgt_tile_out  out  PASS_W  current pass index.
- act_valid_in  in  1  activation window available.
- act_ready_out  out  1  scheduler accepts a window this cycle; issue = act_valid_in & act_ready_out.
- psum_sel_out  out  1  0: row psum_in = 0; 1: row psum_in = psum buffer read data.
- psum_rd_addr_out  out  PIX_W  psum buffer read address (combinational-read buffer).
- psum_wr_en_out  out  1  write row psum_out into psum buffer.
- psum_wr_addr_out  out  PIX_W  write address.
- final_out  out  1  qualifies psum_wr_en_out: write belongs to the last pass.
- stall_cnt_out  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset (async, rst_in low): state IDLE, all counters and the valid pipe cleared. All outputs 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start_in with num_pix_in = 0 or num_pass_in = 0 -> DONE.
  - Other start_in -> LOAD_W; latch both counts, pass = 0.
- LOAD_W (1 cycle): wgt_load_out = 1, wgt_tile_out = pass, pix_cnt = 0, wr_cnt = 0 -> STREAM.
- STREAM:
  - act_ready_out = 1 while pix_cnt < num_pix; in that case psum_rd_addr_out = pix_cnt and psum_sel_out = (pass != 0).
  - On issue: pix_cnt++; a 1 is shifted into a PE_LAT-deep valid pipe (0 otherwise).
  - Issuing the last window (pix_cnt reaches num_pix) -> DRAIN the next cycle.
- Write-back, in STREAM and DRAIN:
  - psum_wr_en_out = valid pipe tail, i.e. exactly PE_LAT cycles after the matching issue.
  - psum_wr_addr_out = wr_cnt; wr_cnt++ on each write, so writes follow issue order.
  - final_out = psum_wr_en_out & (pass == num_pass-1).
- DRAIN:
  - After the write with wr_cnt = num_pix-1: if pass < num_pass-1 then pass++ -> LOAD_W, else -> DONE.
  - Total for a stall-free pass: 1 + num_pix + PE_LAT cycles.
- DONE (1 cycle): done_out = 1 -> IDLE.
- No read/write hazard: the next pass reads only after the current pass has fully drained.
- Stalls: act_valid_in low in STREAM inserts bubbles (zeros) into the valid pipe; the PEs run every cycle and the scheduler never gates them.
- start_in while busy_out = 1: ignored, latched counts unchanged.
- Counts are PIX_W / PASS_W bits; the maximum values are legal and no counter wraps within a job.

Optional Feature:
- Macro: PE_ROW_SCHED_STALL_CNT_EN.
- Defined:
  - stall_cnt_out counts STREAM cycles with act_ready_out = 1 and act_valid_in = 0.
  - Saturates at 16'hFFFF.
  - Cleared on an accepted start_in; holds its value after done_out.
- Undefined: stall_cnt_out tied to 0, no counter logic.

Test Plan:
- ROW_LENGTH = 7, num_pix = 4, num_pass = 1, act_valid_in held 1, start at cycle 0:
  - wgt_load_out at cycle 1; issues at cycles 2-5, psum_sel_out = 0.
  - psum_wr_en_out at cycles 9-12, addresses 0-3, final_out = 1.
  - done_out at cycle 13; busy_out low at cycle 14.
- num_pix = 3, num_pass = 3:
  - wgt_tile_out steps 0, 1, 2; three wgt_load_out pulses.
  - psum_sel_out = 0 in pass 0 and 1 in passes 1-2; psum_rd_addr_out = 0, 1, 2 each pass.
  - final_out only on the 3 writes of pass 2.
- num_pix = 4, act_valid_in pattern 1,0,0,1,1,0,1:
  - Writes land exactly 7 cycles after each issue, addresses 0-3 in order.
  - stall_cnt_out = 3 with PE_ROW_SCHED_STALL_CNT_EN defined, 0 without.
- start_in with num_pix = 0 (then again with num_pass = 0):
  - LOAD_W is skipped and there are no writes.
  - done_out 1 cycle after start; busy_out high for exactly 1 cycle.
- start_in pulsed during STREAM with different counts: ignored; the job completes with the original counts.
- rst_in low mid-DRAIN (asynchronous, between clock edges): all outputs 0 immediately, state IDLE; a new job after reset runs normally from address 0.

Source files
------------

// File: rtl/pe_row_sched.sv
// Sequencer for one binary PE row: weight-tile loads, window issue, psum source select and
// latency-matched psum write-back. Optional stall counter: define PE_ROW_SCHED_STALL_CNT_EN.
module pe_row_sched #(
  parameter int unsigned ROW_LENGTH = 7,
  parameter int unsigned PIX_W      = 10,
  parameter int unsigned PASS_W     = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [PIX_W-1:0]  num_pix_in,
  input  logic [PASS_W-1:0] num_pass_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              wgt_load_out,
  output logic [PASS_W-1:0] wgt_tile_out,
  input  logic              act_valid_in,
  output logic              act_ready_out,
  output logic              psum_sel_out,
  output logic [PIX_W-1:0]  psum_rd_addr_out,
  output logic              psum_wr_en_out,
  output logic [PIX_W-1:0]  psum_wr_addr_out,
  output logic              final_out,
  output logic [15:0]       stall_cnt_out
);

  localparam int unsigned PE_LAT = ROW_LENGTH;

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e              state_q;
  logic [PIX_W-1:0]    num_pix_q, pix_cnt_q, wr_cnt_q;
  logic [PASS_W-1:0]   num_pass_q, pass_q;
  logic [PE_LAT-1:0]   vpipe_q;
  logic                issue, last_pass, last_wr, in_flight;

  always_comb begin
    in_flight        = (state_q == StStream) || (state_q == StDrain);
    act_ready_out    = (state_q == StStream) && (pix_cnt_q < num_pix_q);
    issue            = act_valid_in && act_ready_out;
    psum_rd_addr_out = act_ready_out ? pix_cnt_q : '0;
    psum_sel_out     = act_ready_out && (pass_q != '0);
    // Tail of the valid pipe marks a row result leaving the last PE.
    psum_wr_en_out   = in_flight && vpipe_q[PE_LAT-1];
    psum_wr_addr_out = psum_wr_en_out ? wr_cnt_q : '0;
    last_pass        = (pass_q == num_pass_q - PASS_W'(1));
    last_wr          = (wr_cnt_q == num_pix_q - PIX_W'(1));
    final_out        = psum_wr_en_out && last_pass;
    busy_out         = (state_q != StIdle);
    done_out         = (state_q == StDone);
    wgt_load_out     = (state_q == StLoadW);
    wgt_tile_out     = pass_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      num_pix_q  <= '0;
      num_pass_q <= '0;
      pix_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      pass_q     <= '0;
      vpipe_q    <= '0;
    end else begin
      if (in_flight) begin
        vpipe_q <= (vpipe_q << 1) | PE_LAT'(issue);
      end
      if (psum_wr_en_out) begin
        wr_cnt_q <= wr_cnt_q + PIX_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            if (num_pix_in == '0 || num_pass_in == '0) begin
              state_q <= StDone;
            end else begin
              num_pix_q  <= num_pix_in;
              num_pass_q <= num_pass_in;
              pass_q     <= '0;
              state_q    <= StLoadW;
            end
          end
        end
        StLoadW: begin
          pix_cnt_q <= '0;
          wr_cnt_q  <= '0;
          state_q   <= StStream;
        end
        StStream: begin
          if (issue) begin
            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            if (pix_cnt_q + PIX_W'(1) == num_pix_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Next pass may read the buffer only once every write of this pass has landed.
          if (psum_wr_en_out && last_wr) begin
            if (last_pass) begin
              state_q <= StDone;
            end else begin
              pass_q  <= pass_q + PASS_W'(1);
              state_q <= StLoadW;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef PE_ROW_SCHED_STALL_CNT_EN
  logic        start_ok;
  logic [15:0] stall_cnt_q;

  assign start_ok = start_in && (state_q == StIdle);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if (act_ready_out && !act_valid_in && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`else
  assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pe_row_sched.sv
// Self-checking bench for pe_row_sched: per-job schedule model compared every cycle,
// plus literal timing pins from hand-worked examples.
module tb_pe_row_sched;

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned PASS_W = 4;
  localparam int          LAT    = 7;
  localparam int          N      = 128;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic [PIX_W-1:0]  num_pix_in;
  logic [PASS_W-1:0] num_pass_in;
  logic              busy_out, done_out, wgt_load_out;
  logic [PASS_W-1:0] wgt_tile_out;
  logic              act_valid_in, act_ready_out, psum_sel_out;
  logic [PIX_W-1:0]  psum_rd_addr_out;
  logic              psum_wr_en_out;
  logic [PIX_W-1:0]  psum_wr_addr_out;
  logic              final_out;
  logic [15:0]       stall_cnt_out;

  pe_row_sched #(.ROW_LENGTH(LAT), .PIX_W(PIX_W), .PASS_W(PASS_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .num_pix_in      (num_pix_in),
    .num_pass_in     (num_pass_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .wgt_load_out    (wgt_load_out),
    .wgt_tile_out    (wgt_tile_out),
    .act_valid_in    (act_valid_in),
    .act_ready_out   (act_ready_out),
    .psum_sel_out    (psum_sel_out),
    .psum_rd_addr_out(psum_rd_addr_out),
    .psum_wr_en_out  (psum_wr_en_out),
    .psum_wr_addr_out(psum_wr_addr_out),
    .final_out       (final_out),
    .stall_cnt_out   (stall_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Stimulus per cycle of a job (cycle 0 = start cycle).
  bit vld[N];
  bit xstart[N];

  // Expected outputs per cycle of a job.
  bit e_busy[N], e_done[N], e_wload[N], e_ready[N], e_sel[N], e_wen[N], e_final[N];
  int e_tile[N], e_rdaddr[N], e_waddr[N];
  int e_stall;
  int t_done;

  // Observed event summary of the last job.
  int o_first_wr, o_last_wr, o_done, o_loads, o_finals, o_writes;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, -1, 32'(busy_out), 0);
    chk({tag, ".done"}, -1, 32'(done_out), 0);
    chk({tag, ".wload"}, -1, 32'(wgt_load_out), 0);
    chk({tag, ".tile"}, -1, 32'(wgt_tile_out), 0);
    chk({tag, ".ready"}, -1, 32'(act_ready_out), 0);
    chk({tag, ".sel"}, -1, 32'(psum_sel_out), 0);
    chk({tag, ".rdaddr"}, -1, 32'(psum_rd_addr_out), 0);
    chk({tag, ".wen"}, -1, 32'(psum_wr_en_out), 0);
    chk({tag, ".waddr"}, -1, 32'(psum_wr_addr_out), 0);
    chk({tag, ".final"}, -1, 32'(final_out), 0);
    chk({tag, ".stall"}, -1, 32'(stall_cnt_out), 0);
  endtask

  // Schedule model: each pass = load cycle, then one window per valid cycle,
  // each result written LAT cycles after its issue; next pass after the last write.
  function automatic void build(input int np, input int nq);
    int t, issued, last;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_wload[i] = 0; e_ready[i] = 0; e_sel[i] = 0;
      e_wen[i] = 0; e_final[i] = 0; e_tile[i] = 0; e_rdaddr[i] = 0; e_waddr[i] = 0;
    end
    e_stall = 0;
    if (np == 0 || nq == 0) begin
      e_busy[1] = 1;
      e_done[1] = 1;
      t_done = 1;
      return;
    end
    t = 1;
    for (int p = 0; p < nq; p++) begin
      e_busy[t] = 1; e_wload[t] = 1; e_tile[t] = p;
      t++;
      issued = 0;
      last = t;
      while (issued < np && t < N - LAT - 2) begin
        e_busy[t] = 1; e_ready[t] = 1; e_rdaddr[t] = issued; e_sel[t] = (p != 0);
        if (vld[t]) begin
          e_wen[t+LAT] = 1; e_waddr[t+LAT] = issued; e_final[t+LAT] = (p == nq - 1);
          last = t + LAT;
          issued++;
        end else begin
          e_stall++;
        end
        t++;
      end
      while (t <= last) begin
        e_busy[t] = 1;
        t++;
      end
    end
    e_busy[t] = 1;
    e_done[t] = 1;
    t_done = t;
  endfunction

  task automatic set_vld_all();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1;
      xstart[i] = 0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_job(input string name, input int np, input int nq, input int abort_at);
    build(np, nq);
    o_first_wr = -1; o_last_wr = -1; o_done = -1; o_loads = 0; o_finals = 0; o_writes = 0;
    for (int k = 0; k <= t_done + 2; k++) begin
      chk({name, ".busy"}, k, 32'(busy_out), 32'(e_busy[k]));
      chk({name, ".done"}, k, 32'(done_out), 32'(e_done[k]));
      chk({name, ".wload"}, k, 32'(wgt_load_out), 32'(e_wload[k]));
      if (e_wload[k]) chk({name, ".tile"}, k, 32'(wgt_tile_out), e_tile[k]);
      chk({name, ".ready"}, k, 32'(act_ready_out), 32'(e_ready[k]));
      chk({name, ".sel"}, k, 32'(psum_sel_out), 32'(e_sel[k]));
      chk({name, ".rdaddr"}, k, 32'(psum_rd_addr_out), e_rdaddr[k]);
      chk({name, ".wen"}, k, 32'(psum_wr_en_out), 32'(e_wen[k]));
      if (e_wen[k]) chk({name, ".waddr"}, k, 32'(psum_wr_addr_out), e_waddr[k]);
      chk({name, ".final"}, k, 32'(final_out), 32'(e_final[k]));
      if (psum_wr_en_out) begin
        if (o_first_wr < 0) o_first_wr = k;
        o_last_wr = k;
        o_writes++;
        if (final_out) o_finals++;
      end
      if (wgt_load_out) o_loads++;
      if (done_out) o_done = k;
      start_in     = (k == 0) || xstart[k];
      num_pix_in   = xstart[k] ? PIX_W'(2) : PIX_W'(np);
      num_pass_in  = xstart[k] ? PASS_W'(5) : PASS_W'(nq);
      act_valid_in = vld[k];
      if (k == abort_at) begin
        #1 rst_in = 1'b0;
        start_in = 1'b0;
        act_valid_in = 1'b0;
        #1 chk_zero({name, ".rst"});
        #1 rst_in = 1'b1;
        @(negedge clk_in);
        return;
      end
      @(negedge clk_in);
    end
`ifdef PE_ROW_SCHED_STALL_CNT_EN
    chk({name, ".stall_cnt"}, t_done + 3, 32'(stall_cnt_out), e_stall);
`else
    chk({name, ".stall_cnt"}, t_done + 3, 32'(stall_cnt_out), 0);
`endif
  endtask

  initial begin
    rst_in = 1'b0;
    start_in = 1'b0;
    act_valid_in = 1'b0;
    num_pix_in = '0;
    num_pass_in = '0;
    #2 chk_zero("reset");
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    set_vld_all();
    run_job("basic", 4, 1, -1);
    chk("basic.first_wr", 0, o_first_wr, 9);
    chk("basic.last_wr", 0, o_last_wr, 12);
    chk("basic.done_cyc", 0, o_done, 13);
    chk("basic.finals", 0, o_finals, 4);
    chk("basic.loads", 0, o_loads, 1);

    run_job("multi", 3, 3, -1);
    chk("multi.loads", 0, o_loads, 3);
    chk("multi.finals", 0, o_finals, 3);
    chk("multi.writes", 0, o_writes, 9);
    chk("multi.done_cyc", 0, o_done, 34);

    set_vld_all();
    vld[3] = 0; vld[4] = 0; vld[7] = 0;
    run_job("stall", 4, 1, -1);
    chk("stall.first_wr", 0, o_first_wr, 9);
    chk("stall.last_wr", 0, o_last_wr, 15);
    chk("stall.done_cyc", 0, o_done, 16);
`ifdef PE_ROW_SCHED_STALL_CNT_EN
    chk("stall.cnt_lit", 0, 32'(stall_cnt_out), 3);
`else
    chk("stall.cnt_lit", 0, 32'(stall_cnt_out), 0);
`endif

    set_vld_all();
    run_job("zpix", 0, 5, -1);
    chk("zpix.done_cyc", 0, o_done, 1);
    chk("zpix.writes", 0, o_writes, 0);
    chk("zpix.loads", 0, o_loads, 0);
    run_job("zpass", 3, 0, -1);
    chk("zpass.done_cyc", 0, o_done, 1);
    chk("zpass.writes", 0, o_writes, 0);

    set_vld_all();
    xstart[3] = 1;
    run_job("ignstart", 4, 1, -1);
    chk("ignstart.writes", 0, o_writes, 4);
    chk("ignstart.done_cyc", 0, o_done, 13);

    set_vld_all();
    run_job("abort", 4, 1, 10);
    run_job("after_rst", 4, 1, -1);
    chk("after_rst.first_wr", 0, o_first_wr, 9);
    chk("after_rst.done_cyc", 0, o_done, 13);
    chk("after_rst.finals", 0, o_finals, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
